// File: rtl/hfu_pkg.sv
// -----------------------------------------------------------------------------
// hfu_pkg
// Shared types and helpers for the hazard/forwarding unit.
//   hfu_entry_t  : one in-flight tracker entry {valid, dst, wr, load[, setf]}
//   FWD_RF       : fwd_sel value that selects the register file
//   fwd_sel_w()  : width of one forwarding select for a given tracker depth
// Optional feature macro: HFU_FLAG_TRACK_EN (adds the per-entry setf bit).
// -----------------------------------------------------------------------------
package hfu_pkg;

    // Storage width of a destination index; REG_W of the unit must not exceed it.
    localparam int HFU_DST_W = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic [HFU_DST_W-1:0] dst;
        logic                 wr;
        logic                 load;
`ifdef HFU_FLAG_TRACK_EN
        logic                 setf;
`endif
    } hfu_entry_t;

    // Select 0 is the register file, 1..depth pick a tracker entry.
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hfu_tracker.sv
// -----------------------------------------------------------------------------
// hfu_tracker
// Shift-register of in-flight destination writes. Entry 0 is EX, entry
// DEPTH-1 is the oldest. Every cycle each entry moves one stage older; entry 0
// takes the decoded instruction when push=1, otherwise a bubble.
// Optional feature macro: HFU_FLAG_TRACK_EN (via hfu_entry_t layout).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : decoded instruction advances into EX this cycle
//   new_entry  : decoded instruction fields
//   entries    : current tracker contents
// -----------------------------------------------------------------------------
module hfu_tracker
    import hfu_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  hfu_entry_t             new_entry,
    output hfu_entry_t [DEPTH-1:0] entries
);

    // NOTE: every entry is reset, not just valid bits, because a stale entry
    // left valid after reset would forward or stall against garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's old
            // value; blocking here would collapse the whole shift chain.
            entries[0] <= push ? new_entry : '0;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Hazard and forwarding unit for the pipelined ARM datapath. Tracks in-flight
// destination writes for DEPTH stages, picks the youngest matching writer for
// each source operand, stalls decode on load-use and chooses live vs saved
// flags for B.LT.
// Optional feature macro: HFU_FLAG_TRACK_EN
//   defined   : setf tracked per entry, flag_live driven
//   undefined : id_sets_flags/id_reads_flags ignored, flag_live tied to 0
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   id_valid                 : decode holds a real instruction
//   id_src, id_src_used      : source indices and per-source read enables
//   id_dst, id_wr            : destination index and write enable
//   id_is_load               : LDUR/LDURB
//   id_sets_flags            : ADDS/SUBS
//   id_reads_flags           : B.LT
//   flush                    : squash decode instruction (taken branch)
//   stall                    : hold IF/ID, bubble into EX
//   fwd_sel                  : per source, 0 = regfile, k = entry k-1 result
//   flag_live                : 1 = live ALU flags, 0 = saved flags
//   stall_cnt                : saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_fwd_unit
    import hfu_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int LOAD_LAT = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     id_valid,
    input  logic [NUM_SRC-1:0][REG_W-1:0]            id_src,
    input  logic [NUM_SRC-1:0]                       id_src_used,
    input  logic [REG_W-1:0]                         id_dst,
    input  logic                                     id_wr,
    input  logic                                     id_is_load,
    input  logic                                     id_sets_flags,
    input  logic                                     id_reads_flags,
    input  logic                                     flush,
    output logic                                     stall,
    output logic [NUM_SRC-1:0][fwd_sel_w(DEPTH)-1:0] fwd_sel,
    output logic                                     flag_live,
    output logic [15:0]                              stall_cnt
);

    localparam int SEL_W = fwd_sel_w(DEPTH);

    hfu_entry_t [DEPTH-1:0] entries;
    hfu_entry_t             new_entry;
    logic                   push;
    logic [NUM_SRC-1:0]     src_haz;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.dst   = HFU_DST_W'(id_dst);
        new_entry.wr    = id_wr;
        new_entry.load  = id_is_load;
`ifdef HFU_FLAG_TRACK_EN
        new_entry.setf  = id_sets_flags;
`endif
    end

    // A stalled or flushed instruction stays out of EX; a bubble goes in.
    assign push = id_valid & ~stall & ~flush;

    hfu_tracker #(
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .new_entry (new_entry),
        .entries   (entries)
    );

    // Scan from oldest to youngest so the youngest match overwrites.
    // A source reading ZERO_REG can only match a ZERO_REG writer, which is
    // excluded, so it always falls back to the register file.
    always_comb begin
        // NOTE: defaults first for every combinational output so no path
        // through the loops leaves a value held (which would infer a latch).
        fwd_sel = '0;
        src_haz = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_sel[s] = SEL_W'(FWD_RF);
            if (id_valid && id_src_used[s]) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (entries[k].valid && entries[k].wr &&
                        entries[k].dst == HFU_DST_W'(id_src[s]) &&
                        entries[k].dst != HFU_DST_W'(ZERO_REG)) begin
                        fwd_sel[s] = SEL_W'(k + 1);
                        src_haz[s] = entries[k].load && (k < LOAD_LAT - 1);
                    end
                end
            end
        end
    end

    // Flush wins: the instruction is being squashed, so nothing to wait for.
    assign stall = (|src_haz) & ~flush;

`ifdef HFU_FLAG_TRACK_EN
    // Only a setter directly ahead in EX has flags not yet saved.
    assign flag_live = id_valid & id_reads_flags & entries[0].valid & entries[0].setf;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = id_sets_flags ^ id_reads_flags;
    assign flag_live = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Scoreboard bench for hazard_fwd_unit. The driver applies an instruction,
// predicts the outputs from a history queue of instructions that entered EX,
// and pushes the prediction; a monitor pops and compares on the falling edge.
// Honours HFU_FLAG_TRACK_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 3;
    localparam int REG_W    = 5;
    localparam int ZERO_REG = 31;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = 2;
`ifdef HFU_FLAG_TRACK_EN
    localparam bit FLAG_EN  = 1'b1;
`else
    localparam bit FLAG_EN  = 1'b0;
`endif

    typedef struct packed {
        bit       valid;
        bit [4:0] src0;
        bit [4:0] src1;
        bit [1:0] used;
        bit [4:0] dst;
        bit       wr;
        bit       load;
        bit       setf;
        bit       rdf;
        bit       flush;
    } in_t;

    typedef struct packed {
        bit valid;
        int dst;
        bit wr;
        bit load;
        bit setf;
    } rec_t;

    typedef struct packed {
        bit stall;
        int fwd0;
        int fwd1;
        bit flag;
        int cnt;
    } exp_t;

    logic                              clk;
    logic                              rst;
    logic                              id_valid;
    logic [NUM_SRC-1:0][REG_W-1:0]     id_src;
    logic [NUM_SRC-1:0]                id_src_used;
    logic [REG_W-1:0]                  id_dst;
    logic                              id_wr;
    logic                              id_is_load;
    logic                              id_sets_flags;
    logic                              id_reads_flags;
    logic                              flush;
    logic                              stall;
    logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel;
    logic                              flag_live;
    logic [15:0]                       stall_cnt;

    int   checks = 0;
    int   errors = 0;
    rec_t hist[$];      // hist[0] = youngest instruction that entered EX
    exp_t exp_q[$];
    int   model_cnt = 0;
    in_t  cur;
    bit   cur_stall = 1'b0;

    hazard_fwd_unit #(
        .NUM_SRC  (NUM_SRC),
        .DEPTH    (DEPTH),
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG),
        .LOAD_LAT (LOAD_LAT)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_src         (id_src),
        .id_src_used    (id_src_used),
        .id_dst         (id_dst),
        .id_wr          (id_wr),
        .id_is_load     (id_is_load),
        .id_sets_flags  (id_sets_flags),
        .id_reads_flags (id_reads_flags),
        .flush          (flush),
        .stall          (stall),
        .fwd_sel        (fwd_sel),
        .flag_live      (flag_live),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic in_t mk(bit v, int s0, int s1, bit [1:0] u, int d,
                               bit w, bit ld, bit sf, bit rf, bit fl);
        in_t i;
        i.valid = v;  i.src0 = 5'(s0); i.src1 = 5'(s1); i.used = u;
        i.dst   = 5'(d); i.wr = w; i.load = ld; i.setf = sf; i.rdf = rf; i.flush = fl;
        return i;
    endfunction

    // Expected outputs from the rules: youngest valid writer of the source
    // (by age in EX) is forwarded; a load younger than LOAD_LAT-1 stalls.
    function automatic exp_t predict(input in_t i);
        exp_t e;
        bit   haz;
        int   src;
        int   f;
        haz = 1'b0;
        e.fwd0 = 0;
        e.fwd1 = 0;
        for (int s = 0; s < 2; s++) begin
            src = (s == 0) ? int'(i.src0) : int'(i.src1);
            f = 0;
            if (i.valid && i.used[s] && src != ZERO_REG) begin
                for (int a = 0; a < hist.size(); a++) begin
                    if (hist[a].valid && hist[a].wr && hist[a].dst == src) begin
                        f = a + 1;
                        if (hist[a].load && a < LOAD_LAT - 1) haz = 1'b1;
                        break;
                    end
                end
            end
            if (s == 0) e.fwd0 = f; else e.fwd1 = f;
        end
        e.stall = haz && !i.flush;
        e.flag  = FLAG_EN && i.valid && i.rdf && hist[0].valid && hist[0].setf;
        e.cnt   = model_cnt;
        return e;
    endfunction

    task automatic apply(input in_t i);
        exp_t e;
        cur            = i;
        id_valid       = i.valid;
        id_src[0]      = i.src0;
        id_src[1]      = i.src1;
        id_src_used    = i.used;
        id_dst         = i.dst;
        id_wr          = i.wr;
        id_is_load     = i.load;
        id_sets_flags  = i.setf;
        id_reads_flags = i.rdf;
        flush          = i.flush;
        e = predict(i);
        cur_stall = e.stall;
        exp_q.push_back(e);
    endtask

    task automatic step();
        rec_t r;
        @(posedge clk);
        r.valid = cur.valid && !cur_stall && !cur.flush;
        r.dst   = int'(cur.dst);
        r.wr    = cur.wr;
        r.load  = cur.load;
        r.setf  = cur.setf;
        hist.push_front(r);
        void'(hist.pop_back());
        if (cur_stall && model_cnt < 65535) model_cnt++;
        #1;
    endtask

    task automatic model_reset();
        rec_t b;
        b = '0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(b);
        model_cnt = 0;
        cur_stall = 1'b0;
    endtask

    function automatic bit [4:0] rreg();
        int r;
        r = $urandom_range(0, 6);
        return (r == 6) ? 5'd31 : 5'(r);
    endfunction

    function automatic in_t rand_ins();
        return mk($urandom_range(0, 9) != 0, int'(rreg()), int'(rreg()),
                  2'($urandom_range(0, 3)), int'(rreg()),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0);
    endfunction

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", {31'b0, stall}, {31'b0, e.stall});
                if (!e.stall) begin
                    check("fwd_sel0", {30'b0, fwd_sel[0]}, e.fwd0);
                    check("fwd_sel1", {30'b0, fwd_sel[1]}, e.fwd1);
                end
                check("flag_live", {31'b0, flag_live}, {31'b0, e.flag});
                check("stall_cnt", {16'b0, stall_cnt}, e.cnt);
            end
        end
    end

    initial begin
        in_t nop;
        in_t ri;
        nop = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        apply(nop);
        void'(exp_q.pop_back());   // idle inputs only; nothing to score during reset
        #3;
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_fwd", {28'b0, fwd_sel}, 0);
        check("rst_flag", {31'b0, flag_live}, 0);
        check("rst_cnt", {16'b0, stall_cnt}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADDS X1 then uses of X1 at ages 1, 2, 3.
        apply(mk(1, 0, 0, 2'b00, 1, 1, 0, 1, 0, 0)); step();
        apply(mk(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 0)); #2 check("dir_age1", {30'b0, fwd_sel[0]}, 1); step();
        apply(mk(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 0)); #2 check("dir_age2", {30'b0, fwd_sel[0]}, 2); step();
        apply(mk(1, 1, 0, 2'b01, 9, 0, 0, 0, 0, 0)); #2 check("dir_age3", {30'b0, fwd_sel[0]}, 3); step();

        // Two writers to X2 at entries 2 and 0: youngest wins.
        apply(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 0, 0)); step();
        apply(mk(1, 0, 0, 2'b00, 9, 0, 0, 0, 0, 0)); step();
        apply(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 0, 0)); step();
        apply(mk(1, 0, 2, 2'b10, 9, 0, 0, 0, 0, 0)); #2 check("dir_youngest", {30'b0, fwd_sel[1]}, 1); step();

        // LDUR X3 then use: one stall cycle, then forward from entry 1.
        apply(mk(1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0)); step();
        apply(mk(1, 3, 0, 2'b01, 9, 0, 0, 0, 0, 0)); #2 check("dir_lu_stall", {31'b0, stall}, 1); step();
        apply(mk(1, 3, 0, 2'b01, 9, 0, 0, 0, 0, 0)); #2;
        check("dir_lu_release", {31'b0, stall}, 0);
        check("dir_lu_fwd", {30'b0, fwd_sel[0]}, 2);
        check("dir_lu_cnt", {16'b0, stall_cnt}, 1);
        step();

        // Writer and reader of X31 never forward or stall.
        apply(mk(1, 0, 0, 2'b00, 31, 1, 1, 0, 0, 0)); step();
        apply(mk(1, 31, 31, 2'b11, 9, 0, 0, 0, 0, 0)); #2;
        check("dir_xzr_fwd", {28'b0, fwd_sel}, 0);
        check("dir_xzr_stall", {31'b0, stall}, 0);
        step();

        // Flush during load-use: no stall, and the flushed writer of X5 is a bubble.
        apply(mk(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0)); step();
        apply(mk(1, 4, 0, 2'b01, 5, 1, 0, 0, 0, 1)); #2 check("dir_flush_stall", {31'b0, stall}, 0); step();
        apply(mk(1, 4, 5, 2'b11, 9, 0, 0, 0, 0, 0)); #2 check("dir_flush_bubble", {30'b0, fwd_sel[1]}, 0); step();

        // SUBS then B.LT, and with one instruction between.
        apply(mk(1, 0, 0, 2'b00, 6, 1, 0, 1, 0, 0)); step();
        apply(mk(1, 0, 0, 2'b00, 9, 0, 0, 0, 1, 0)); #2 check("dir_flag_adj", {31'b0, flag_live}, {31'b0, FLAG_EN}); step();
        apply(mk(1, 0, 0, 2'b00, 6, 1, 0, 1, 0, 0)); step();
        apply(mk(1, 0, 0, 2'b00, 9, 0, 0, 0, 0, 0)); step();
        apply(mk(1, 0, 0, 2'b00, 9, 0, 0, 0, 1, 0)); #2 check("dir_flag_gap", {31'b0, flag_live}, 0); step();

        // Reset in the middle of a stall clears everything at once.
        apply(mk(1, 0, 0, 2'b00, 7, 1, 1, 1, 0, 0)); step();
        apply(mk(1, 7, 7, 2'b11, 9, 0, 0, 0, 1, 0)); #2 check("dir_pre_rst_stall", {31'b0, stall}, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_rst_stall", {31'b0, stall}, 0);
        check("async_rst_fwd", {28'b0, fwd_sel}, 0);
        check("async_rst_flag", {31'b0, flag_live}, 0);
        check("async_rst_cnt", {16'b0, stall_cnt}, 0);
        model_reset();
        apply(nop);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;

        // Random phase; a stalled instruction is normally held in decode.
        ri = rand_ins();
        for (int n = 0; n < 600; n++) begin
            if (!cur_stall) ri = rand_ins();
            else if ($urandom_range(0, 4) == 0) ri.flush = 1'b1;
            apply(ri);
            step();
        end

        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
